// File: rtl/tt6502_pkg.sv
// tt6502_pkg: shared op encodings, P-register flag positions and serial ALU state type.
package tt6502_pkg;
    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;
    localparam int FLAG_C = 0;
    localparam int FLAG_Z = 1;
    localparam int FLAG_V = 6;
    localparam int FLAG_N = 7;
    typedef enum logic {ST_IDLE, ST_RUN} state_e;
endpackage

// File: rtl/bcd_byte_adder.sv
// bcd_byte_adder: one-byte binary/BCD add-subtract with carry and binary signed overflow.
module bcd_byte_adder
    import tt6502_pkg::*;
(
    input  logic [7:0] a_i,
    input  logic [7:0] b_i,
    input  logic       c_i,
    input  logic       sub_i,
    input  logic       dec_i,
    output logic [7:0] y_o,
    output logic       c_o,
    output logic       v_o
);
    logic       s;
    logic [7:0] bx;
    logic [8:0] bin;
    logic [4:0] lo, hi;
    logic       lc, hc;
    logic [3:0] lo_adj, hi_adj;
    always_comb begin
        s      = sub_i == OP_SUB;
        bx     = s ? ~b_i : b_i;
        bin    = {1'b0, a_i} + {1'b0, bx} + {8'b0, c_i};
        v_o    = (a_i[7] == bx[7]) && (bin[7] != a_i[7]);
        // lc/hc mean nibble borrow when subtracting, decimal carry when adding
        lo     = s ? {1'b0, a_i[3:0]} - {1'b0, b_i[3:0]} - {4'b0, !c_i}
                   : {1'b0, a_i[3:0]} + {1'b0, b_i[3:0]} + {4'b0, c_i};
        lc     = s ? lo[4] : lo > 5'd9;
        hi     = s ? {1'b0, a_i[7:4]} - {1'b0, b_i[7:4]} - {4'b0, lc}
                   : {1'b0, a_i[7:4]} + {1'b0, b_i[7:4]} + {4'b0, lc};
        hc     = s ? hi[4] : hi > 5'd9;
        lo_adj = lc ? (s ? lo[3:0] - 4'd6 : lo[3:0] + 4'd6) : lo[3:0];
        hi_adj = hc ? (s ? hi[3:0] - 4'd6 : hi[3:0] + 4'd6) : hi[3:0];
        y_o    = dec_i ? {hi_adj, lo_adj} : bin[7:0];
        c_o    = dec_i ? (s ? !hc : hc) : bin[8];
    end
endmodule

// File: rtl/serial_byte_alu.sv
// serial_byte_alu: LSB-first byte-serial add/subtract of NBYTES-byte words with 6502 BCD and N/V/Z/C flags.
module serial_byte_alu
    import tt6502_pkg::*;
#(
    parameter int NBYTES     = 2,
    parameter int DECIMAL_EN = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clear,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] a_in,
    input  logic [7:0] b_in,
    input  logic       sub,
    input  logic       dec,
    input  logic       cin,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] y_out,
    output logic       out_last,
    output logic       flag_c,
    output logic       flag_z,
    output logic       flag_n,
    output logic       flag_v
);
    state_e     state_q, state_d;
    logic [2:0] idx_q, idx_d;
    logic       sub_q, sub_d, dec_q, dec_d, carry_q, carry_d, z_q, z_d;
    logic       ov_q, ov_d, last_q, last_d;
    logic [7:0] y_q, y_d;
    logic       fc_q, fc_d, fz_q, fz_d, fn_q, fn_d, fv_q, fv_d;
    logic       acc, first, last, sub_w, dec_w, c_w, z_w, c_o, v_o;
    logic [7:0] y_w;

    assign in_ready  = !ov_q || out_ready;
    assign acc       = in_valid && in_ready;
    assign first     = state_q == ST_IDLE;
    assign last      = idx_q == 3'(NBYTES - 1);
    // op and carry-in come from the pins on byte 0, from the latched copies afterwards
    assign sub_w     = first ? sub : sub_q;
    assign dec_w     = (DECIMAL_EN != 0) && (first ? dec : dec_q);
    assign c_w       = first ? cin : carry_q;
    assign z_w       = (y_w == 8'h00) && (first || z_q);
    assign out_valid = ov_q;
    assign y_out     = y_q;
    assign out_last  = last_q;
    assign flag_c    = fc_q;
    assign flag_z    = fz_q;
    assign flag_n    = fn_q;
    assign flag_v    = fv_q;

    bcd_byte_adder u_add (
        .a_i  (a_in),
        .b_i  (b_in),
        .c_i  (c_w),
        .sub_i(sub_w),
        .dec_i(dec_w),
        .y_o  (y_w),
        .c_o  (c_o),
        .v_o  (v_o)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        sub_d   = sub_q;
        dec_d   = dec_q;
        carry_d = carry_q;
        z_d     = z_q;
        ov_d    = ov_q && !out_ready;
        y_d     = y_q;
        last_d  = last_q;
        fc_d    = fc_q;
        fz_d    = fz_q;
        fn_d    = fn_q;
        fv_d    = fv_q;
        if (clear) begin
            state_d = ST_IDLE;
            idx_d   = 3'd0;
            carry_d = 1'b0;
            ov_d    = 1'b0;
            last_d  = 1'b0;
        end else if (acc) begin
            state_d = last ? ST_IDLE : ST_RUN;
            idx_d   = last ? 3'd0 : idx_q + 3'd1;
            sub_d   = sub_w;
            dec_d   = dec_w;
            carry_d = c_o;
            z_d     = z_w;
            ov_d    = 1'b1;
            y_d     = y_w;
            last_d  = last;
            fc_d    = last ? c_o : fc_q;
            fz_d    = last ? z_w : fz_q;
            fn_d    = last ? y_w[7] : fn_q;
            fv_d    = last ? v_o : fv_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            idx_q   <= 3'd0;
            sub_q   <= OP_ADD;
            dec_q   <= 1'b0;
            carry_q <= 1'b0;
            z_q     <= 1'b0;
            ov_q    <= 1'b0;
            y_q     <= 8'h00;
            last_q  <= 1'b0;
            fc_q    <= 1'b0;
            fz_q    <= 1'b0;
            fn_q    <= 1'b0;
            fv_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            sub_q   <= sub_d;
            dec_q   <= dec_d;
            carry_q <= carry_d;
            z_q     <= z_d;
            ov_q    <= ov_d;
            y_q     <= y_d;
            last_q  <= last_d;
            fc_q    <= fc_d;
            fz_q    <= fz_d;
            fn_q    <= fn_d;
            fv_q    <= fv_d;
        end
    end
endmodule

// File: tb/tb_serial_byte_alu.sv
// tb_serial_byte_alu: random and directed words checked against a word-level arithmetic model.
module tb_serial_byte_alu;
    localparam int NB = 2;

    logic       clk, rst, clear, in_valid, in_ready, sub, dec, cin;
    logic       out_valid, out_ready, out_last, flag_c, flag_z, flag_n, flag_v;
    logic [7:0] a_in, b_in, y_out;

    typedef struct {
        logic [7:0] y;
        logic       last;
        logic [3:0] f;
    } exp_t;

    exp_t       q[$];
    int         vec = 0, errs = 0;
    int         rdy_mode = 1;
    logic       rdy_force = 1'b1;
    logic       hold_v = 1'b0;
    logic [7:0] hold_y;
    logic [4:0] hold_f;
    logic [3:0] exp_flags = 4'h0;

    serial_byte_alu #(.NBYTES(NB), .DECIMAL_EN(1)) dut (
        .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
        .a_in(a_in), .b_in(b_in), .sub(sub), .dec(dec), .cin(cin),
        .out_valid(out_valid), .out_ready(out_ready), .y_out(y_out), .out_last(out_last),
        .flag_c(flag_c), .flag_z(flag_z), .flag_n(flag_n), .flag_v(flag_v)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int bcd2i(input logic [15:0] x);
        return int'(x[15:12]) * 1000 + int'(x[11:8]) * 100 + int'(x[7:4]) * 10 + int'(x[3:0]);
    endfunction

    function automatic logic [15:0] i2bcd(input int x);
        return {4'(x / 1000), 4'((x / 100) % 10), 4'((x / 10) % 10), 4'(x % 10)};
    endfunction

    // whole-word result; f = {N, V, Z, C}
    task automatic model(input logic [15:0] A, input logic [15:0] B, input logic s, input logic d,
                         input logic ci, output logic [15:0] r, output logic [3:0] f);
        int t, ad, bd, cl, sa, sb, sv;
        logic c, v;
        if (!d) begin
            t  = s ? int'(A) - int'(B) - int'(!ci) : int'(A) + int'(B) + int'(ci);
            c  = s ? t >= 0 : t >= 65536;
            r  = t[15:0];
            sv = s ? int'($signed(A)) - int'($signed(B)) - int'(!ci)
                   : int'($signed(A)) + int'($signed(B)) + int'(ci);
            v  = sv > 32767 || sv < -32768;
        end else begin
            ad = bcd2i(A);
            bd = bcd2i(B);
            t  = s ? ad - bd - int'(!ci) : ad + bd + int'(ci);
            c  = s ? t >= 0 : t >= 10000;
            r  = i2bcd((t + 10000) % 10000);
            cl = s ? int'(ad % 100 - bd % 100 - int'(!ci) >= 0) : int'(ad % 100 + bd % 100 + int'(ci) >= 100);
            sa = int'($signed(A[15:8]));
            sb = s ? int'($signed(~B[15:8])) : int'($signed(B[15:8]));
            sv = sa + sb + cl;
            v  = sv > 127 || sv < -128;
        end
        f = {r[15], v, r == 16'h0000, c};
    endtask

    task automatic pin(input string name, input logic [15:0] A, input logic [15:0] B, input logic s,
                       input logic d, input logic ci, input logic [15:0] er, input logic [3:0] ef);
        logic [15:0] r;
        logic [3:0]  f;
        model(A, B, s, d, ci, r, f);
        chk({name, "_word"}, r, er);
        chk({name, "_nvzc"}, f, ef);
    endtask

    task automatic send_word(input logic [15:0] A, input logic [15:0] B, input logic s, input logic d,
                             input logic ci, input int nb, input bit push);
        logic [15:0] r;
        logic [3:0]  f;
        logic [15:0] av, bv;
        bit acc;
        int to, gap;
        exp_t e;
        av = A;
        bv = B;
        model(A, B, s, d, ci, r, f);
        if (push)
            for (int i = 0; i < nb; i++) begin
                e.y = r[8*i +: 8];
                e.last = (i == NB - 1);
                e.f = f;
                q.push_back(e);
            end
        for (int i = 0; i < nb; i++) begin
            gap = (rdy_mode == 0) ? $urandom_range(0, 2) : 0;
            repeat (gap) begin @(posedge clk); #1; end
            in_valid = 1'b1;
            a_in = av[8*i +: 8];
            b_in = bv[8*i +: 8];
            sub  = (i == 0) ? s  : 1'($urandom);
            dec  = (i == 0) ? d  : 1'($urandom);
            cin  = (i == 0) ? ci : 1'($urandom);
            acc = 0;
            to = 0;
            while (!acc && to < 200) begin
                @(negedge clk);
                acc = in_ready;
                @(posedge clk);
                #1;
                to++;
            end
            if (!acc) begin
                vec++;
                errs++;
                $display("FAIL accept_timeout: byte %0d not accepted within 200 cycles", i);
            end
            in_valid = 1'b0;
            a_in = 8'($urandom);
            b_in = 8'($urandom);
        end
    endtask

    function automatic logic [15:0] rnd_bcd();
        return {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
    endfunction

    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            out_ready = (rdy_mode == 0) ? ($urandom_range(0, 3) != 0) : (rdy_mode == 1) ? 1'b1 : rdy_force;
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            hold_v = 1'b0;
            exp_flags = 4'h0;
        end else begin
            chk("in_ready", in_ready, !out_valid || out_ready);
            if (hold_v && out_valid) begin
                chk("hold_y", y_out, hold_y);
                chk("hold_flags", {out_last, flag_n, flag_v, flag_z, flag_c}, hold_f);
            end
            hold_v = out_valid && !out_ready;
            hold_y = y_out;
            hold_f = {out_last, flag_n, flag_v, flag_z, flag_c};
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    vec++;
                    errs++;
                    $display("FAIL unexpected_byte: got %0h with nothing expected", y_out);
                end else begin
                    e = q.pop_front();
                    chk("y_out", y_out, e.y);
                    chk("out_last", out_last, e.last);
                    chk("flags_nvzc", {flag_n, flag_v, flag_z, flag_c}, e.last ? e.f : exp_flags);
                    if (e.last) exp_flags = e.f;
                end
            end
        end
    end

    initial begin
        int to;
        logic [15:0] A, B;
        logic s, d;
        rst = 1'b1;
        clear = 1'b0;
        in_valid = 1'b0;
        a_in = 8'h00;
        b_in = 8'h00;
        sub = 1'b0;
        dec = 1'b0;
        cin = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_y_out", y_out, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_flags", {flag_n, flag_v, flag_z, flag_c}, 0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        pin("bin_add", 16'h12FF, 16'h0001, 0, 0, 0, 16'h1300, 4'b0000);
        pin("bin_sub", 16'h0000, 16'h0001, 1, 0, 1, 16'hFFFF, 4'b1000);
        pin("dec_add", 16'h0999, 16'h0001, 0, 1, 0, 16'h1000, 4'b0000);
        pin("dec_wrap", 16'h9999, 16'h0001, 0, 1, 0, 16'h0000, 4'b0011);
        pin("ovf", 16'h7FFF, 16'h0001, 0, 0, 0, 16'h8000, 4'b1100);
        pin("dec_sub", 16'h0100, 16'h0001, 1, 1, 1, 16'h0099, 4'b0001);

        rdy_mode = 1;
        send_word(16'h12FF, 16'h0001, 0, 0, 0, NB, 1);
        send_word(16'h0000, 16'h0001, 1, 0, 1, NB, 1);
        send_word(16'h0999, 16'h0001, 0, 1, 0, NB, 1);
        send_word(16'h9999, 16'h0001, 0, 1, 0, NB, 1);
        send_word(16'h7FFF, 16'h0001, 0, 0, 0, NB, 1);
        send_word(16'h0100, 16'h0001, 1, 1, 1, NB, 1);

        rdy_mode = 2;
        rdy_force = 1'b0;
        fork
            send_word(16'h12FF, 16'h0001, 0, 0, 0, NB, 1);
            begin
                to = 0;
                while (!out_valid && to < 50) begin @(negedge clk); to++; end
                repeat (3) @(negedge clk);
                rdy_force = 1'b1;
            end
        join

        rdy_mode = 1;
        send_word(16'h00FF, 16'h0001, 0, 0, 1, 1, 1);
        clear = 1'b1;
        in_valid = 1'b1;
        a_in = 8'h55;
        b_in = 8'h55;
        @(posedge clk);
        #1;
        clear = 1'b0;
        in_valid = 1'b0;
        send_word(16'h0001, 16'h0001, 0, 0, 0, NB, 1);

        rdy_mode = 2;
        rdy_force = 1'b0;
        @(posedge clk);
        #1;
        send_word(16'h00FF, 16'h0001, 0, 0, 1, 1, 0);
        chk("pre_rst_out_valid", out_valid, 1);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_out_valid", out_valid, 0);
        chk("async_rst_y_out", y_out, 0);
        chk("async_rst_flags", {out_last, flag_n, flag_v, flag_z, flag_c}, 0);
        chk("async_rst_in_ready", in_ready, 1);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        rdy_mode = 1;
        send_word(16'h0001, 16'h0001, 0, 0, 0, NB, 1);

        rdy_mode = 0;
        for (int k = 0; k < 200; k++) begin
            s = 1'($urandom);
            d = 1'($urandom);
            A = d ? rnd_bcd() : 16'($urandom);
            B = d ? rnd_bcd() : 16'($urandom);
            if (k % 16 == 0) B = d ? 16'h0000 : A;
            send_word(A, B, s, d, 1'($urandom), NB, 1);
        end

        rdy_mode = 1;
        to = 0;
        while (q.size() != 0 && to < 1000) begin @(posedge clk); to++; end
        if (q.size() != 0) begin
            vec++;
            errs++;
            $display("FAIL drain_timeout: %0d bytes never delivered", q.size());
        end
        repeat (2) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end
endmodule
